// File: rtl/video_pattern_gen_pkg.sv
// Shared types, default 1280x720 timing and the active-region predicate
// for the video pattern generator.
package video_timing_pkg;

  typedef enum logic [1:0] {
    COL_RAMP = 2'd0,
    ROW_RAMP = 2'd1,
    CHECKER  = 2'd2,
    SOLID    = 2'd3
  } pattern_mode_e;

  localparam int unsigned DEF_H_SYNC     = 40;
  localparam int unsigned DEF_H_BACK     = 220;
  localparam int unsigned DEF_H_DISP     = 1280;
  localparam int unsigned DEF_H_FRONT    = 110;
  localparam int unsigned DEF_V_SYNC     = 5;
  localparam int unsigned DEF_V_BACK     = 20;
  localparam int unsigned DEF_V_DISP     = 720;
  localparam int unsigned DEF_V_FRONT    = 5;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 12;

  // True when (h, v) lies inside the displayed rectangle.
  function automatic logic in_active(input int unsigned h,
                                     input int unsigned v,
                                     input int unsigned h_start,
                                     input int unsigned h_disp,
                                     input int unsigned v_start,
                                     input int unsigned v_disp);
    return (h >= h_start) && (h < h_start + h_disp) &&
           (v >= v_start) && (v < v_start + v_disp);
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Pixel stream bundle: sync, qualifier and data towards the frame buffer.
interface video_pattern_gen_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  img_vsync;
  logic                  img_hsync;
  logic                  img_valid;
  logic [DATA_WIDTH-1:0] img_data;

  modport master (
    output img_vsync,
    output img_hsync,
    output img_valid,
    output img_data
  );

  modport slave (
    input img_vsync,
    input img_hsync,
    input img_valid,
    input img_data
  );

endinterface

// File: rtl/video_pattern_gen_timing_cnt.sv
// Horizontal/vertical position counters with frame wrap and position flags.
// Counters sit at (0,0) whenever run is low.
module video_timing_cnt #(
  parameter int unsigned H_TOTAL   = 1650,
  parameter int unsigned V_TOTAL   = 750,
  parameter int unsigned CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic [CNT_WIDTH-1:0] h_cnt,
  output logic [CNT_WIDTH-1:0] v_cnt,
  output logic                 first_pos,
  output logic                 last_pos
);

  localparam logic [CNT_WIDTH-1:0] H_LAST = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  // Advance the raster position; wrap line then frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
    end else begin
      h_cnt <= h_cnt + ONE;
    end
  end

  assign first_pos = (h_cnt == '0) && (v_cnt == '0);
  assign last_pos  = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source: run/stop FSM on frame boundaries,
// per-frame pattern latch, registered sync/valid/data decode and frame count.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned H_DISP     = DEF_H_DISP,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned V_DISP     = DEF_V_DISP,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] solid_value,
  video_pattern_gen_if.master   img,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned V_START = V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_e;

  state_e state;
  state_e state_nxt;

  logic                 run;
  logic [CNT_WIDTH-1:0] h_cnt;
  logic [CNT_WIDTH-1:0] v_cnt;
  logic                 first_pos;
  logic                 last_pos;

  pattern_mode_e         mode_q;
  logic [DATA_WIDTH-1:0] solid_q;

  pattern_mode_e         cur_mode;
  logic [DATA_WIDTH-1:0] cur_solid;
  logic [CNT_WIDTH-1:0]  x_rel;
  logic [CNT_WIDTH-1:0]  y_rel;
  logic                  checker_on;
  logic                  active;
  logic                  vsync_d;
  logic                  hsync_d;
  logic                  valid_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  done_d;

  assign run = (state != IDLE);

  video_timing_cnt #(
    .H_TOTAL   (H_TOTAL),
    .V_TOTAL   (V_TOTAL),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .first_pos (first_pos),
    .last_pos  (last_pos)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: stop requests only take effect at the last frame position.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) state_nxt = STOP_PEND;
      end
      STOP_PEND: begin
        if (enable)        state_nxt = RUN;
        else if (last_pos) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the pattern selection at the first position of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= COL_RAMP;
      solid_q <= '0;
    end else if (run && first_pos) begin
      mode_q  <= pattern_mode_e'(mode);
      solid_q <= solid_value;
    end
  end

  // Output decode from the current raster position and frame pattern.
  always_comb begin
    // At (0,0) the latch is being loaded this cycle, so use the live inputs.
    cur_mode   = first_pos ? pattern_mode_e'(mode) : mode_q;
    cur_solid  = first_pos ? solid_value : solid_q;
    x_rel      = h_cnt - CNT_WIDTH'(H_START);
    y_rel      = v_cnt - CNT_WIDTH'(V_START);
    checker_on = 1'((32'(x_rel) ^ 32'(y_rel)) >> 4);
    active     = in_active(32'(h_cnt), 32'(v_cnt), H_START, H_DISP, V_START, V_DISP);
    vsync_d    = 1'b0;
    hsync_d    = 1'b0;
    valid_d    = 1'b0;
    data_d     = '0;
    done_d     = 1'b0;
    if (run) begin
      vsync_d = (32'(v_cnt) < V_SYNC);
      hsync_d = (32'(h_cnt) < H_SYNC);
      valid_d = active;
      done_d  = last_pos;
      if (active) begin
        unique case (cur_mode)
          COL_RAMP: data_d = DATA_WIDTH'(h_cnt);
          ROW_RAMP: data_d = DATA_WIDTH'(y_rel);
          CHECKER:  data_d = checker_on ? '1 : '0;
          SOLID:    data_d = cur_solid;
          default:  data_d = '0;
        endcase
      end
    end
  end

  // Output registers, frame counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img.img_vsync <= 1'b0;
      img.img_hsync <= 1'b0;
      img.img_valid <= 1'b0;
      img.img_data  <= '0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
      busy          <= 1'b0;
    end else begin
      img.img_vsync <= vsync_d;
      img.img_hsync <= hsync_d;
      img.img_valid <= valid_d;
      img.img_data  <= data_d;
      frame_done    <= done_d;
      busy          <= run;
      if (done_d) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: small-timing instance checked
// against a position-based reference model, plus a 32x32 instance for the
// checkerboard.
module tb_video_pattern_gen;

  localparam int unsigned HT    = 15;
  localparam int unsigned VT    = 8;
  localparam int unsigned FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  solid_value = 8'd0;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        busy;

  logic        enable2 = 1'b0;
  logic [1:0]  mode2 = 2'd0;
  logic [7:0]  solid2 = 8'd0;
  logic        frame_done2;
  logic [15:0] frame_cnt2;
  logic        busy2;

  int unsigned checks = 0;
  int unsigned passed = 0;

  video_pattern_gen_if #(.DATA_WIDTH(8)) v1 ();
  video_pattern_gen_if #(.DATA_WIDTH(8)) v2 ();

  video_pattern_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .DATA_WIDTH(8), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .solid_value(solid_value), .img(v1), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  video_pattern_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(32), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_DISP(32), .V_FRONT(1),
    .DATA_WIDTH(8), .CNT_WIDTH(12)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .mode(mode2),
    .solid_value(solid2), .img(v2), .frame_done(frame_done2),
    .frame_cnt(frame_cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Reference model: frame position p in [0, FRAME), plus run/stop flags.
  bit          m_on;
  bit          m_stop;
  int unsigned m_p;
  logic [1:0]  m_mode;
  logic [7:0]  m_solid;
  logic [10:0] e_pix;
  logic        e_done;
  logic [15:0] e_cnt;
  logic        e_busy;

  function automatic logic [10:0] model_pix(input int unsigned p, input logic [1:0] md,
                                            input logic [7:0] sv);
    int unsigned h, v;
    logic act;
    logic [7:0] d;
    h = p % HT;
    v = p / HT;
    act = (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
    d = 8'h00;
    if (act) begin
      case (md)
        2'd0: d = 8'(h);
        2'd1: d = 8'(v - 3);
        2'd2: d = ((((h - 5) / 16) % 2) != (((v - 3) / 16) % 2)) ? 8'hFF : 8'h00;
        default: d = sv;
      endcase
    end
    return {(v < 1), (h < 2), act, d};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on <= 0; m_stop <= 0; m_p <= 0; m_mode <= 0; m_solid <= 0;
      e_pix <= '0; e_done <= 0; e_cnt <= '0; e_busy <= 0;
    end else begin
      e_busy <= m_on;
      if (m_on) begin
        e_pix  <= model_pix(m_p, (m_p == 0) ? mode : m_mode, (m_p == 0) ? solid_value : m_solid);
        e_done <= (m_p == FRAME - 1);
        if (m_p == FRAME - 1) e_cnt <= e_cnt + 16'd1;
        if (m_p == 0) begin
          m_mode  <= mode;
          m_solid <= solid_value;
        end
        m_p <= (m_p == FRAME - 1) ? 0 : m_p + 1;
        if (m_stop) begin
          if (enable) m_stop <= 0;
          else if (m_p == FRAME - 1) m_on <= 0;
        end else if (!enable) begin
          m_stop <= 1;
        end
      end else begin
        e_pix  <= '0;
        e_done <= 0;
        if (enable) begin
          m_on <= 1; m_stop <= 0; m_p <= 0;
        end
      end
    end
  end

  function automatic logic [28:0] obs1();
    return {v1.img_vsync, v1.img_hsync, v1.img_valid, v1.img_data, frame_done, frame_cnt, busy};
  endfunction

  function automatic logic [28:0] exp1();
    return {e_pix, e_done, e_cnt, e_busy};
  endfunction

  function automatic logic [28:0] obs2();
    return {v2.img_vsync, v2.img_hsync, v2.img_valid, v2.img_data, frame_done2, frame_cnt2, busy2};
  endfunction

  task automatic wait_done(input int unsigned budget, output bit ok);
    ok = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs1() !== 29'd0) $display("FAIL reset_state1: got %h want %h", obs1(), 29'd0);
    else passed++;
    checks++;
    if (obs2() !== 29'd0) $display("FAIL reset_state2: got %h want %h", obs2(), 29'd0);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    int unsigned busy_cyc = 0;
    int unsigned dones = 0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge clk);
      checks++;
      if (obs1() !== exp1()) $display("FAIL single_model cyc %0d: got %h want %h", i, obs1(), exp1());
      else passed++;
      if (busy) busy_cyc++;
      if (frame_done) dones++;
      if (busy_cyc > 0 && !busy) begin
        checks++;
        if ({v1.img_vsync, v1.img_hsync, v1.img_valid, v1.img_data} !== 11'd0)
          $display("FAIL single_quiet cyc %0d: got %h want 0", i,
                   {v1.img_vsync, v1.img_hsync, v1.img_valid, v1.img_data});
        else passed++;
      end
    end
    checks++;
    if (busy_cyc !== 120) $display("FAIL single_busy_cycles: got %0d want 120", busy_cyc);
    else passed++;
    checks++;
    if (dones !== 1) $display("FAIL single_done_count: got %0d want 1", dones);
    else passed++;
    checks++;
    if (frame_cnt !== 16'd1) $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt);
    else passed++;
  endtask

  task automatic test_continuous();
    bit seen = 0;
    int last_done = -1;
    int unsigned dones = 0;
    @(negedge clk);
    enable = 1'b1;
    mode = 2'd0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      checks++;
      if (obs1() !== exp1()) $display("FAIL cont_model cyc %0d: got %h want %h", i, obs1(), exp1());
      else passed++;
      if (busy) seen = 1;
      if (seen) begin
        checks++;
        if (busy !== 1'b1) $display("FAIL cont_gap cyc %0d: busy got %b want 1", i, busy);
        else passed++;
      end
      if (frame_done) begin
        dones++;
        if (last_done >= 0) begin
          checks++;
          if (i - last_done != 120) $display("FAIL cont_spacing: got %0d want 120", i - last_done);
          else passed++;
        end
        last_done = i;
      end
      if (i == 60) enable = 1'b0;
      if (i == 70) enable = 1'b1;
    end
    checks++;
    if (dones !== 3) $display("FAIL cont_done_count: got %0d want 3", dones);
    else passed++;
  endtask

  task automatic test_col_ramp();
    bit ok;
    int unsigned nval = 0, nhs = 0, nvs = 0, ndone = 0, done_at = 0;
    mode = 2'd0;
    enable = 1'b1;
    wait_done(300, ok);
    checks++;
    if (!ok) $display("FAIL col_wait: got timeout want frame_done");
    else passed++;
    for (int unsigned i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs1() !== exp1()) $display("FAIL col_model cyc %0d: got %h want %h", i, obs1(), exp1());
      else passed++;
      if (v1.img_valid) begin
        checks++;
        if (v1.img_data !== 8'(5 + nval % 8))
          $display("FAIL col_data pix %0d: got %h want %h", nval, v1.img_data, 8'(5 + nval % 8));
        else passed++;
        nval++;
      end
      if (v1.img_hsync) nhs++;
      if (v1.img_vsync) nvs++;
      if (frame_done) begin ndone++; done_at = i; end
    end
    checks++;
    if ({nval, nhs, nvs} !== {32'd32, 32'd16, 32'd15})
      $display("FAIL col_counts: got valid %0d hs %0d vs %0d want 32 16 15", nval, nhs, nvs);
    else passed++;
    checks++;
    if (ndone !== 1 || done_at !== FRAME - 1)
      $display("FAIL col_done: got %0d at %0d want 1 at 119", ndone, done_at);
    else passed++;
  endtask

  task automatic test_row_ramp();
    bit ok;
    int unsigned nval = 0;
    mode = 2'd1;
    wait_done(300, ok);
    checks++;
    if (!ok) $display("FAIL row_wait: got timeout want frame_done");
    else passed++;
    for (int unsigned i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (obs1() !== exp1()) $display("FAIL row_model cyc %0d: got %h want %h", i, obs1(), exp1());
      else passed++;
      if (v1.img_valid) begin
        checks++;
        if (v1.img_data !== 8'(nval / 8))
          $display("FAIL row_data pix %0d: got %h want %h", nval, v1.img_data, 8'(nval / 8));
        else passed++;
        nval++;
      end
    end
    checks++;
    if (nval !== 32) $display("FAIL row_count: got %0d want 32", nval);
    else passed++;
  endtask

  task automatic test_solid_switch();
    bit ok;
    bit done = 0;
    int unsigned nval = 0;
    mode = 2'd3;
    solid_value = 8'hA5;
    wait_done(300, ok);
    checks++;
    if (!ok) $display("FAIL solid_wait: got timeout want frame_done");
    else passed++;
    for (int unsigned i = 0; i < 130 && !done; i++) begin
      @(negedge clk);
      checks++;
      if (obs1() !== exp1()) $display("FAIL solid_model cyc %0d: got %h want %h", i, obs1(), exp1());
      else passed++;
      if (v1.img_valid) begin
        checks++;
        if (v1.img_data !== 8'hA5) $display("FAIL solid_data pix %0d: got %h want a5", nval, v1.img_data);
        else passed++;
        nval++;
      end
      if (frame_done) done = 1;
      if (i == 40) begin
        mode = 2'd0;
        solid_value = 8'h3C;
      end
    end
    checks++;
    if (!done || nval !== 32) $display("FAIL solid_frame: got done %0d valid %0d want 1 32", done, nval);
    else passed++;
    nval = 0;
    for (int unsigned i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (v1.img_valid) begin
        checks++;
        if (v1.img_data !== 8'(5 + nval % 8))
          $display("FAIL solid_next_ramp pix %0d: got %h want %h", nval, v1.img_data, 8'(5 + nval % 8));
        else passed++;
        nval++;
      end
    end
  endtask

  task automatic test_checker();
    int unsigned px[5] = '{16, 16, 0, 0, 31};
    int unsigned py[5] = '{0, 16, 0, 16, 31};
    logic [7:0]  pv[5] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
    bit ok = 0;
    bit done = 0;
    bit prev = 0;
    int unsigned x = 0, y = 0, hits = 0;
    enable2 = 1'b1;
    mode2 = 2'd2;
    for (int unsigned i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done2) begin ok = 1; break; end
    end
    checks++;
    if (!ok) $display("FAIL chk_wait: got timeout want frame_done");
    else passed++;
    for (int unsigned i = 0; i < 1500 && !done; i++) begin
      @(negedge clk);
      if (v2.img_valid) begin
        for (int unsigned k = 0; k < 5; k++) begin
          if (x == px[k] && y == py[k]) begin
            hits++;
            checks++;
            if (v2.img_data !== pv[k])
              $display("FAIL chk_pixel (%0d,%0d): got %h want %h", x, y, v2.img_data, pv[k]);
            else passed++;
          end
        end
        x++;
      end else if (prev) begin
        x = 0;
        y++;
      end
      prev = v2.img_valid;
      if (frame_done2) done = 1;
    end
    checks++;
    if (hits !== 5 || y !== 32) $display("FAIL chk_coverage: got hits %0d lines %0d want 5 32", hits, y);
    else passed++;
    enable2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    enable = 1'b1;
    mode = 2'($urandom_range(0, 3));
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_on && (m_p / HT == 4) && (m_p % HT == 7)) begin ok = 1; break; end
    end
    checks++;
    if (!ok) $display("FAIL rstmid_wait: got timeout want v_cnt 4");
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs1() !== 29'd0) $display("FAIL rstmid_async: got %h want 0", obs1());
    else passed++;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs1() !== 29'd0) $display("FAIL rstmid_hold cyc %0d: got %h want 0", i, obs1());
      else passed++;
    end
    mode = 2'd0;
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (obs1() !== exp1()) $display("FAIL rstmid_model cyc %0d: got %h want %h", i, obs1(), exp1());
      else passed++;
    end
    checks++;
    if (frame_cnt !== 16'd1) $display("FAIL rstmid_frame_cnt: got %0d want 1", frame_cnt);
    else passed++;
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (obs1() !== exp1()) $display("FAIL rand_model cyc %0d: got %h want %h", i, obs1(), exp1());
      else passed++;
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) solid_value = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_col_ramp();
    test_row_ramp();
    test_solid_switch();
    test_checker();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
Synthesizable, parametrised video timing and test-pattern source that drives the pre_img_* stream into the DDR frame-buffer path (axi_ddr_top) on hardware, without a bench-side stimulus task. Generates hsync/vsync/valid/data for any resolution and pixel width. Four selectable patterns are latched per frame. Frames can be started and stopped cleanly on frame boundaries, with a frame-done pulse and a frame counter.

Parameters:
H_SYNC, 40, line sync width in clocks
H_BACK, 220, line back porch
H_DISP, 1280, active pixels per line
H_FRONT, 110, line front porch
V_SYNC, 5, frame sync width in lines
V_BACK, 20, frame back porch
V_DISP, 720, active lines per frame
V_FRONT, 5, frame front porch
DATA_WIDTH, 8, pixel width in bits
CNT_WIDTH, 12, width of the h/v counters; must satisfy 2^CNT_WIDTH > max(H_TOTAL, V_TOTAL)
Derived (localparam): H_TOTAL = sum of the four H_* values; V_TOTAL = sum of the four V_* values.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request, level-sensitive
mode  in  2  pattern select: 0 column ramp, 1 row ramp, 2 checkerboard, 3 solid
solid_value  in  DATA_WIDTH  pixel value for mode 3
img_vsync  out  1  frame sync, active high
img_hsync  out  1  line sync, active high
img_valid  out  1  active-pixel qualifier
img_data  out  DATA_WIDTH  pixel data
frame_done  out  1  one-cycle pulse on the last pixel position of a frame
frame_cnt  out  16  completed-frame count
busy  out  1  high while not IDLE

Behaviour:
- Reset: all outputs 0. Counters h_cnt and v_cnt are 0. State is IDLE.
- FSM states:
  - IDLE: counters held at 0; all img_* outputs 0. enable=1 -> RUN.
  - RUN: h_cnt increments every clk. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. At (H_TOTAL-1, V_TOTAL-1), both wrap to 0. enable=0 -> STOP_PEND.
  - STOP_PEND: counting continues. enable=1 -> RUN, with no gap in the counters. At (H_TOTAL-1, V_TOTAL-1) -> IDLE, counters to 0.
- Frame start: the first counted position is (0,0), on the clk after the IDLE->RUN transition.
- Pattern latch: mode and solid_value are captured when the counters are at (0,0) in RUN. The captured values hold for the whole frame. Mid-frame changes to mode or solid_value have no effect on the current frame.
- Output decode, registered, 1 clk latency from the counters:
  - img_vsync = v_cnt < V_SYNC
  - img_hsync = h_cnt < H_SYNC
  - img_valid = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP)
- Active coordinates: x = h_cnt - (H_SYNC+H_BACK); y = v_cnt - (V_SYNC+V_BACK).
- Data by mode, when img_valid=1:
  - mode 0: h_cnt[DATA_WIDTH-1:0]. This is the raw line counter, not x, to stay compatible with existing golden files.
  - mode 1: y[DATA_WIDTH-1:0]
  - mode 2: all ones if x[4]^y[4], else 0 (16x16 checkerboard)
  - mode 3: solid_value
  - When img_valid=0, img_data=0.
- If DATA_WIDTH > CNT_WIDTH, ramp values are zero-extended.
- frame_done is registered and aligned with the output of position (H_TOTAL-1, V_TOTAL-1). In the same cycle, frame_cnt increments and wraps 0xFFFF -> 0.
- busy = state != IDLE. busy is registered and drops on the clk after the final frame_done.
- Reset mid-frame: immediate return to reset values. frame_cnt is cleared. A partial frame produces no frame_done.
- Single-frame mode: enable pulsed for 1 clk produces exactly one full frame.

Decomposition:
- Package video_timing_pkg holds:
  - the pattern_mode_e enum (COL_RAMP, ROW_RAMP, CHECKER, SOLID)
  - default 1280x720 timing localparams
  - a function computing the active-region predicate
- Sub-module video_timing_cnt holds the h/v counters, wrap logic and last-position flag. It is parametrised by H_TOTAL, V_TOTAL and CNT_WIDTH, and has inputs clk, rst_n and run.
- The top level holds the FSM, the pattern latch, the decode/output registers and frame_cnt.

Test Plan:
All cases use small timing: H=2/3/8/2 (H_TOTAL 15), V=1/2/4/1 (V_TOTAL 8), DATA_WIDTH 8.
1. enable held high, mode 0 -> each line has 8 valid pixels with data 05..0C. Lines with valid are v_cnt 3..6. hsync is high for 2 clks per line; vsync is high for 15 clks. frame_done fires every 120 clks.
2. mode 1, one frame -> 4 active lines carry data 00, 01, 02, 03 respectively, 8 pixels each.
3. mode 2 with H_DISP=32, V_DISP=32 -> pixel (x=16, y=0) = FF; (x=16, y=16) = 00; (x=0, y=0) = 00.
4. mode 3 with solid_value=A5; switch mode to 0 mid-frame -> remainder of the frame is A5; the next frame is the ramp.
5. enable pulsed 1 clk -> exactly 120 clks of counting, one frame_done, frame_cnt=1, busy drops; outputs then stay 0. Drop and re-raise enable mid-frame -> no gap, continuous frames.
6. Assert rst_n low at mid-frame (v_cnt=4) -> all outputs 0 asynchronously, frame_cnt=0, no frame_done; restart yields correct first frame.
